if_fetch: RTL and testbench

Instruction-fetch stage: holds the program counter, issues in-order word fetches to instruction memory over a request/grant/response handshake, and buffers returned words in a 2-entry queue. It presents one {pc, instruction} pair per cycle to the decode stage (`id`) through an output register. It honours a decode-side stall and a branch/jump redirect with flush. Invalid slots are sent to decode as the NOP encoding.

---
 rtl/if_fetch_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 51 +++++
 rtl/if_fetch.sv | 161 ++++++++++++++++
 tb/tb_if_fetch.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared widths, encodings and payload types for the instruction-fetch stage.
package if_fetch_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;
    localparam int unsigned CntW        = 2;

    localparam logic                   RstEnable = 1'b1;
    localparam logic [InstBus-1:0]     ZeroWord  = 32'h0000_0000;
    localparam logic [InstBus-1:0]     NopInst   = 32'h0000_0013;
    localparam logic [InstAddrBus-1:0] ResetPc   = 32'h0000_0000;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_pair_t;

    // Word-align an address by clearing the two byte-offset bits.
    function automatic logic [InstAddrBus-1:0] align_pc(input logic [InstAddrBus-1:0] addr);
        return addr & ~InstAddrBus'(3);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, inst} pairs between the memory response and decode.
module fetch_queue
    import if_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  fetch_pair_t       din,
    output fetch_pair_t       dout,
    output logic [CntW-1:0]   count,
    output logic              empty,
    output logic              full
);

    fetch_pair_t           mem_q [2];
    logic                  wr_q;
    logic                  rd_q;
    logic [CntW-1:0]       cnt_q;

    // Storage, pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= '0;
        end else if (flush) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= din;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
        end
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CntW'(2));

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, credit-limited memory requests, response
// buffering and the registered {pc, inst, valid} hand-off to decode.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = ResetPc
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [CntW-1:0]        out_q, out_d;
    logic [CntW-1:0]        disc_q, disc_d;
    logic [InstAddrBus-1:0] shadow_q [2];
    logic                   sh_wr_q;
    logic                   sh_rd_q;

    logic [InstAddrBus-1:0] pc_o_d;
    logic [InstBus-1:0]     inst_o_d;
    logic                   valid_o_d;

    logic                   credit_ok;
    logic                   fire;
    logic                   rsp_drop;
    logic                   rsp_keep;
    logic                   loadable;
    fetch_pair_t            rsp_pair;

    logic                   q_push;
    logic                   q_pop;
    logic                   q_flush;
    fetch_pair_t            q_head;
    logic [CntW-1:0]        q_count;
    logic                   q_empty;
    logic                   q_full;

    fetch_queue u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .pop   (q_pop),
        .flush (q_flush),
        .din   (rsp_pair),
        .dout  (q_head),
        .count (q_count),
        .empty (q_empty),
        .full  (q_full)
    );

    // Request only from registered state; words in flight plus queued never exceed two.
    always_comb begin
        credit_ok   = (3'(out_q) + 3'(q_count)) < 3'd2;
        imem_req_o  = (rst != RstEnable) && !redirect_i && credit_ok;
        imem_addr_o = pc_q;
        fire        = imem_req_o && imem_gnt_i;
        rsp_drop    = imem_rvalid_i && (disc_q != '0);
        rsp_keep    = imem_rvalid_i && (disc_q == '0) && !redirect_i;
        loadable    = !stall_i || !valid_o;
        rsp_pair    = '{pc: shadow_q[sh_rd_q], inst: imem_rdata_i};
    end

    // Next PC, counters, queue control and output-register contents.
    always_comb begin
        pc_d      = pc_q;
        out_d     = out_q + CntW'(fire) - CntW'(imem_rvalid_i);
        disc_d    = disc_q - CntW'(rsp_drop);
        q_push    = 1'b0;
        q_pop     = 1'b0;
        q_flush   = 1'b0;
        pc_o_d    = pc_o;
        inst_o_d  = inst_o;
        valid_o_d = valid_o;

        if (fire) begin
            pc_d = pc_q + 32'd4;
        end

        if (redirect_i) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_d      = align_pc(redirect_pc_i);
            q_flush   = 1'b1;
            valid_o_d = 1'b0;
            inst_o_d  = NopInst;
            disc_d    = out_d;
        end else if (loadable) begin
            if (!q_empty) begin
                pc_o_d    = q_head.pc;
                inst_o_d  = q_head.inst;
                valid_o_d = 1'b1;
                q_pop     = 1'b1;
                q_push    = rsp_keep;
            end else if (rsp_keep) begin
                pc_o_d    = rsp_pair.pc;
                inst_o_d  = rsp_pair.inst;
                valid_o_d = 1'b1;
            end else begin
                valid_o_d = 1'b0;
                inst_o_d  = NopInst;
            end
        end else begin
            q_push = rsp_keep;
        end
    end

    // PC, outstanding/discard counters and the decode-facing output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            out_q   <= '0;
            disc_q  <= '0;
            pc_o    <= ZeroWord;
            inst_o  <= NopInst;
            valid_o <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
            pc_o    <= pc_o_d;
            inst_o  <= inst_o_d;
            valid_o <= valid_o_d;
        end
    end

    // In-flight PC shadow: written on grant, consumed by every response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q[0] <= ZeroWord;
            shadow_q[1] <= ZeroWord;
            sh_wr_q     <= 1'b0;
            sh_rd_q     <= 1'b0;
        end else begin
            if (fire) begin
                shadow_q[sh_wr_q] <= pc_q;
                sh_wr_q           <= ~sh_wr_q;
            end
            if (imem_rvalid_i) begin
                sh_rd_q <= ~sh_rd_q;
            end
        end
    end

    // The credit rule must make a push into a full, non-popping queue impossible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(q_push && q_full && !q_pop));
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios with literal expectations followed by
// randomized traffic, all checked against a transaction-level model.
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        valid_o;

    if_fetch #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .valid_o       (valid_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } pair_t;

    // Model state: requests in flight (oldest first), words waiting for decode, output.
    req_t        outst[$];
    pair_t       buff[$];
    logic [31:0] m_pc;
    logic [31:0] m_out_pc;
    logic [31:0] m_out_inst;
    bit          m_out_valid;

    // Memory: addresses granted but not yet answered.
    logic [31:0] mq[$];

    logic        cap_req  = 1'b0;
    logic [31:0] cap_addr = '0;

    bit          knob_rst = 1'b1;
    bit          knob_stall = 1'b0;
    bit          knob_redir = 1'b0;
    logic [31:0] knob_rpc = '0;
    int          knob_gnt = 1;  // 0 random, 1 always, 2 never
    int          knob_rsp = 1;  // 0 random, 1 always, 2 never
    bit          knob_random = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_req();
        return !redirect_i && ((outst.size() + buff.size()) < 2);
    endfunction

    task automatic model_reset();
        outst.delete();
        buff.delete();
        mq.delete();
        m_pc        = RST_PC;
        m_out_pc    = '0;
        m_out_inst  = NOP;
        m_out_valid = 1'b0;
    endtask

    task automatic model_step();
        bit   req;
        bit   have;
        req_t e;
        req  = m_req();
        have = 1'b0;
        e    = '{pc: 32'h0, stale: 1'b0};
        if (imem_rvalid_i && mq.size() > 0) void'(mq.pop_front());
        if (cap_req && imem_gnt_i) mq.push_back(cap_addr);
        if (imem_rvalid_i && outst.size() > 0) begin
            e    = outst.pop_front();
            have = 1'b1;
        end
        if (req && imem_gnt_i) begin
            outst.push_back('{pc: m_pc, stale: 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (redirect_i) begin
            foreach (outst[i]) outst[i].stale = 1'b1;
            buff.delete();
            m_out_valid = 1'b0;
            m_out_inst  = NOP;
            m_pc        = {redirect_pc_i[31:2], 2'b00};
        end else begin
            if (have && !e.stale) buff.push_back('{pc: e.pc, inst: word_at(e.pc)});
            if (!stall_i || !m_out_valid) begin
                if (buff.size() > 0) begin
                    pair_t p;
                    p           = buff.pop_front();
                    m_out_pc    = p.pc;
                    m_out_inst  = p.inst;
                    m_out_valid = 1'b1;
                end else begin
                    m_out_valid = 1'b0;
                    m_out_inst  = NOP;
                end
            end
        end
    endtask

    // Model and memory advance on every rising edge.
    always @(posedge clk) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Compare process: every cycle, mid-period.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", 32'(valid_o), 32'h0);
            chk("rst_pc", pc_o, 32'h0);
            chk("rst_inst", inst_o, NOP);
            chk("rst_req", 32'(imem_req_o), 32'h0);
        end else begin
            chk("valid", 32'(valid_o), 32'(m_out_valid));
            chk("pc", pc_o, m_out_pc);
            chk("inst", inst_o, m_out_inst);
            chk("req", 32'(imem_req_o), 32'(m_req()));
            chk("addr", imem_addr_o, m_pc);
        end
    end

    task automatic drive_cycle();
        @(posedge clk);
        #1;
        if (knob_random) knob_rst = ($urandom_range(0, 999) < 3);
        rst = knob_rst;
        if (rst) begin
            stall_i       = 1'b0;
            redirect_i    = 1'b0;
            imem_gnt_i    = 1'b0;
            imem_rvalid_i = 1'b0;
        end else begin
            if (knob_random) begin
                stall_i    = ($urandom_range(0, 99) < 30);
                redirect_i = ($urandom_range(0, 99) < 3);
                if ($urandom_range(0, 3) == 0) redirect_pc_i = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                else                           redirect_pc_i = $urandom;
                imem_gnt_i    = ($urandom_range(0, 99) < 70);
                imem_rvalid_i = ($urandom_range(0, 99) < 70) && (mq.size() > 0);
            end else begin
                stall_i       = knob_stall;
                redirect_i    = knob_redir;
                redirect_pc_i = knob_rpc;
                imem_gnt_i    = (knob_gnt == 1) || (knob_gnt == 0 && $urandom_range(0, 1) == 1);
                imem_rvalid_i = (mq.size() > 0) &&
                                ((knob_rsp == 1) || (knob_rsp == 0 && $urandom_range(0, 1) == 1));
            end
            knob_redir   = 1'b0;
            imem_rdata_i = imem_rvalid_i ? word_at(mq[0]) : $urandom;
        end
        #1;
        cap_req  = imem_req_o;
        cap_addr = imem_addr_o;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected < 2000000", $time);
        $fatal(1);
    end

    initial begin
        bit found;
        model_reset();
        knob_rst = 1'b1;
        repeat (3) drive_cycle();

        // Straight-line fetch from RESET_PC, always-grant, 1-cycle memory.
        knob_rst = 1'b0;
        knob_gnt = 1;
        knob_rsp = 1;
        drive_cycle();
        chk("p1_addr0", cap_addr, 32'h0000_0100);
        chk("p1_req0", 32'(cap_req), 32'h1);
        drive_cycle();
        chk("p1_addr1", cap_addr, 32'h0000_0104);
        chk("p1_valid_early", 32'(valid_o), 32'h0);
        drive_cycle();
        chk("p1_addr2", cap_addr, 32'h0000_0108);
        chk("p1_first_valid", 32'(valid_o), 32'h1);
        chk("p1_first_pc", pc_o, 32'h0000_0100);
        chk("p1_first_inst", inst_o, word_at(32'h0000_0100));
        drive_cycle();
        chk("p1_second_pc", pc_o, 32'h0000_0104);
        repeat (3) drive_cycle();

        // Decode stall for 5 cycles: credit runs out after two words are buffered.
        knob_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_cycle();
            if (i >= 2) chk("stall_req_low", 32'(cap_req), 32'h0);
        end
        knob_stall = 1'b0;
        repeat (6) drive_cycle();

        // Redirect to 0x2002 with two requests outstanding.
        knob_rsp = 2;
        for (int i = 0; i < 8 && outst.size() < 2; i++) drive_cycle();
        chk("rd_two_outstanding", 32'(outst.size()), 32'h2);
        knob_redir = 1'b1;
        knob_rpc   = 32'h0000_2002;
        drive_cycle();
        drive_cycle();
        chk("rd_addr", cap_addr, 32'h0000_2000);
        chk("rd_valid_low", 32'(valid_o), 32'h0);
        knob_rsp = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            drive_cycle();
            if (valid_o) found = 1'b1;
        end
        chk("rd_target_seen", 32'(found), 32'h1);
        chk("rd_target_pc", pc_o, 32'h0000_2000);
        repeat (4) drive_cycle();

        // Grant withheld for three cycles, then resumed.
        knob_gnt = 2;
        repeat (3) drive_cycle();
        knob_gnt = 1;
        repeat (6) drive_cycle();

        // Address wrap from the last word of the address space.
        knob_redir = 1'b1;
        knob_rpc   = 32'hFFFF_FFFE;
        drive_cycle();
        drive_cycle();
        chk("wrap_target", cap_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 10 && cap_addr == 32'hFFFF_FFFC; i++) drive_cycle();
        chk("wrap_addr", cap_addr, 32'h0000_0000);
        repeat (6) drive_cycle();

        // Reset pulse with the queue full.
        knob_stall = 1'b1;
        repeat (6) drive_cycle();
        knob_rst = 1'b1;
        drive_cycle();
        chk("mid_rst_valid", 32'(valid_o), 32'h0);
        chk("mid_rst_pc", pc_o, 32'h0);
        chk("mid_rst_inst", inst_o, NOP);
        chk("mid_rst_req", 32'(imem_req_o), 32'h0);
        knob_rst   = 1'b0;
        knob_stall = 1'b0;
        drive_cycle();
        chk("mid_rst_restart", cap_addr, RST_PC);
        repeat (4) drive_cycle();

        // Randomized traffic.
        knob_random = 1'b1;
        repeat (3000) drive_cycle();
        knob_random = 1'b0;
        knob_rst    = 1'b0;
        repeat (4) drive_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
